vid_out_timing_gen: RTL and testbench

Final stage on the read side of the frame buffer. It consumes the frame buffer's output AXI4-Stream (tuser = start of frame, tlast = end of line) and drives a native parallel video interface (data, DE, HSYNC, VSYNC) from free-running timing counters. It locks the stream to the raster at frame boundaries and back-pressures the stream outside the active region. On underflow or framing errors it drops lock and re-synchronises.

---
 rtl/vid_out_timing_gen_if.sv | 14 +
 rtl/vid_out_timing_gen.sv | 119 +++++++++++
 tb/tb_vid_out_timing_gen.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vid_out_timing_gen_if.sv
// AXI4-Stream bundle carrying the frame buffer's pixel stream (tuser = SOF, tlast = EOL).
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 16,
    parameter int TUSER_WIDTH = 1
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/vid_out_timing_gen.sv
// Raster timing generator that locks an AXI4-Stream pixel source to the frame; all outputs 1 clock after counters.
// Back-pressures the stream in blanking; flushes non-SOF beats while unlocked and holds SOF until the frame boundary.
module vid_out_timing_gen #(
    parameter int TDATA_WIDTH = 16,
    parameter int H_ACTIVE    = 1920,
    parameter int H_FP        = 88,
    parameter int H_SYNC      = 44,
    parameter int H_BP        = 148,
    parameter int V_ACTIVE    = 1080,
    parameter int V_FP        = 4,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 36,
    parameter bit HS_POL      = 1'b1,
    parameter bit VS_POL      = 1'b1
) (
    input  logic                   rd_clk_i,
    input  logic                   rd_rst_i,
    axi4_stream_if.slave           video_i,
    output logic [TDATA_WIDTH-1:0] vid_data_o,
    output logic                   vid_de_o,
    output logic                   vid_hs_o,
    output logic                   vid_vs_o,
    output logic                   locked_o,
    output logic                   underflow_o,
    output logic                   desync_o
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          h_cnt;
    logic [VW-1:0]          v_cnt;
    logic                   h_wrap, v_last, frame_end, origin, line_end;
    logic                   active, hs_raw, vs_raw, sof;
    logic                   ready, accept, underflow_d, desync_d;
    logic [TDATA_WIDTH-1:0] data_d;

    assign h_wrap    = (h_cnt == HW'(H_TOTAL - 1));
    assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
    assign frame_end = h_wrap && v_last;
    assign origin    = (h_cnt == '0) && (v_cnt == '0);
    assign line_end  = (h_cnt == HW'(H_ACTIVE - 1));
    assign active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    assign hs_raw    = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_raw    = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign sof       = video_i.tuser[0];

    always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
        if (rd_rst_i) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        accept      = 1'b0;
        underflow_d = 1'b0;
        desync_d    = 1'b0;
        data_d      = '0;
        case (state_q)
            UNLOCKED: begin
                // Drain junk, but leave the SOF beat in place to become pixel (0,0).
                ready = !(video_i.tvalid && sof);
                if (frame_end && video_i.tvalid && sof) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                ready       = active && !(sof && !origin);
                accept      = ready && video_i.tvalid;
                underflow_d = active && !video_i.tvalid;
                desync_d    = (active && video_i.tvalid && sof && !origin)
                            || (accept && origin && !sof)
                            || (accept && (video_i.tlast != line_end));
                if (accept) begin
                    data_d = video_i.tdata;
                end
                if (underflow_d || desync_d) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    assign video_i.tready = ready && !rd_rst_i;
    assign locked_o       = (state_q == LOCKED);

    always_ff @(posedge rd_clk_i or posedge rd_rst_i) begin
        if (rd_rst_i) begin
            state_q     <= UNLOCKED;
            vid_data_o  <= '0;
            vid_de_o    <= 1'b0;
            vid_hs_o    <= !HS_POL;
            vid_vs_o    <= !VS_POL;
            underflow_o <= 1'b0;
            desync_o    <= 1'b0;
        end else begin
            state_q     <= state_d;
            vid_data_o  <= data_d;
            vid_de_o    <= active;
            vid_hs_o    <= hs_raw ? HS_POL : !HS_POL;
            vid_vs_o    <= vs_raw ? VS_POL : !VS_POL;
            underflow_o <= underflow_d;
            desync_o    <= desync_d;
        end
    end
endmodule

// File: tb/tb_vid_out_timing_gen.sv
// Randomized bench for vid_out_timing_gen on a 14x7 raster, checked against a frame-position model.
module tb_vid_out_timing_gen;
    localparam int DW  = 16;
    localparam int H_A = 8, H_F = 2, H_S = 2, H_B = 2;
    localparam int V_A = 4, V_F = 1, V_S = 1, V_B = 1;
    localparam int HT  = H_A + H_F + H_S + H_B;
    localparam int VT  = V_A + V_F + V_S + V_B;
    localparam int FT  = HT * VT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] vid_data;
    logic          vid_de, vid_hs, vid_vs, locked, underflow, desync;

    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(1)) vbus ();

    vid_out_timing_gen #(
        .TDATA_WIDTH(DW), .H_ACTIVE(H_A), .H_FP(H_F), .H_SYNC(H_S), .H_BP(H_B),
        .V_ACTIVE(V_A), .V_FP(V_F), .V_SYNC(V_S), .V_BP(V_B), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .rd_clk_i(clk), .rd_rst_i(rst), .video_i(vbus),
        .vid_data_o(vid_data), .vid_de_o(vid_de), .vid_hs_o(vid_hs), .vid_vs_o(vid_vs),
        .locked_o(locked), .underflow_o(underflow), .desync_o(desync)
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t q[$];
    int    n_tests = 0, n_fail = 0;

    // Model: k = cycles since reset release, which fixes the raster position.
    int            k = 0;
    bit            m_locked = 1'b0;
    logic [DW-1:0] e_data = '0;
    logic          e_de = 1'b0, e_hs = 1'b0, e_vs = 1'b0, e_uf = 1'b0, e_ds = 1'b0;

    bit autofill = 1'b0, rand_data = 1'b0, bad_next = 1'b0, drop_armed = 1'b0;
    int gap_pct = 0;
    int uf_seen = 0, ds_seen = 0, uf_pos = -1, ds_pos = -1, lock_pos = -1;
    int cnt_de = 0, cnt_hs = 0, cnt_vs = 0;
    bit prev_locked = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (k=%0d pos=%0d)", tag, got, exp, k, k % FT);
        end
    endtask

    task automatic push_frame(input bit bad);
        int llen;
        llen = bad ? H_A - 1 : H_A;
        for (int ln = 0; ln < V_A; ln++) begin
            for (int x = 0; x < llen; x++) begin
                beat_t b;
                b.d = rand_data ? DW'($urandom) : DW'(ln * llen + x);
                b.u = (ln == 0) && (x == 0);
                b.l = (x == llen - 1);
                q.push_back(b);
            end
        end
    endtask

    task automatic drive();
        bit drop;
        drop = 1'b0;
        if (autofill && q.size() < 32) begin
            push_frame(bad_next);
            bad_next = 1'b0;
        end
        if (drop_armed && m_locked && (k % FT) == HT + 3) begin
            drop       = 1'b1;
            drop_armed = 1'b0;
        end
        if (gap_pct > 0 && $urandom_range(99) < gap_pct) drop = 1'b1;
        if (q.size() > 0 && !drop) begin
            vbus.tvalid   = 1'b1;
            vbus.tdata    = q[0].d;
            vbus.tuser[0] = q[0].u;
            vbus.tlast    = q[0].l;
        end else begin
            // Idle cycles carry garbage sidebands, which must not matter without tvalid.
            vbus.tvalid   = 1'b0;
            vbus.tdata    = DW'($urandom);
            vbus.tuser[0] = 1'($urandom);
            vbus.tlast    = 1'($urandom);
        end
    endtask

    task automatic step();
        int            fpos, h, ln;
        bit            v, u, l, act, org, rdy, acc, uf, ds, nl, hsk;
        logic [DW-1:0] d;
        @(negedge clk);
        if (rst) begin
            k = 0; m_locked = 1'b0; e_data = '0;
            e_de = 1'b0; e_hs = 1'b0; e_vs = 1'b0; e_uf = 1'b0; e_ds = 1'b0;
        end
        fpos = k % FT; h = fpos % HT; ln = fpos / HT;
        v = vbus.tvalid; u = vbus.tuser[0]; l = vbus.tlast; d = vbus.tdata;
        act = (h < H_A) && (ln < V_A);
        org = (fpos == 0);
        acc = 1'b0; uf = 1'b0; ds = 1'b0;
        if (!m_locked) begin
            rdy = !(v && u);
            nl  = (fpos == FT - 1) && v && u;
        end else begin
            rdy = act && !(u && !org);
            acc = act && v && rdy;
            uf  = act && !v;
            ds  = (act && v && u && !org) || (acc && org && !u) || (acc && (l != (h == H_A - 1)));
            nl  = !(uf || ds);
        end
        if (rst) rdy = 1'b0;

        chk_eq("tready",    32'(vbus.tready), 32'(rdy));
        chk_eq("vid_data",  32'(vid_data),    32'(e_data));
        chk_eq("vid_de",    32'(vid_de),      32'(e_de));
        chk_eq("vid_hs",    32'(vid_hs),      32'(e_hs));
        chk_eq("vid_vs",    32'(vid_vs),      32'(e_vs));
        chk_eq("locked",    32'(locked),      32'(m_locked));
        chk_eq("underflow", 32'(underflow),   32'(e_uf));
        chk_eq("desync",    32'(desync),      32'(e_ds));

        if (underflow === 1'b1) begin uf_seen++; uf_pos = fpos; end
        if (desync === 1'b1) begin ds_seen++; ds_pos = fpos; end
        if (locked === 1'b1 && !prev_locked) lock_pos = fpos;
        prev_locked = (locked === 1'b1);
        if (vid_de === 1'b1) cnt_de++;
        if (vid_hs === 1'b1) cnt_hs++;
        if (vid_vs === 1'b1) cnt_vs++;
        hsk = (vbus.tvalid === 1'b1) && (vbus.tready === 1'b1);

        @(posedge clk);
        if (!rst) begin
            if (hsk && q.size() > 0) void'(q.pop_front());
            e_de     = act;
            e_hs     = (h >= H_A + H_F) && (h < H_A + H_F + H_S);
            e_vs     = (ln >= V_A + V_F) && (ln < V_A + V_F + V_S);
            e_data   = acc ? d : '0;
            e_uf     = uf;
            e_ds     = ds;
            m_locked = nl;
            k++;
        end
        #1;
        drive();
    endtask

    task automatic clear_stats();
        uf_seen = 0; ds_seen = 0; uf_pos = -1; ds_pos = -1; lock_pos = -1;
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        drive();
        repeat (3) step();
        rst = 1'b0;

        // Free-running raster with no stream.
        repeat (2 * FT) step();
        clear_stats();
        repeat (FT) step();
        chk_eq("s1_de_per_frame", 32'(cnt_de), 32'(H_A * V_A));
        chk_eq("s1_hs_per_frame", 32'(cnt_hs), 32'(H_S * VT));
        chk_eq("s1_vs_per_frame", 32'(cnt_vs), 32'(V_S * HT));
        chk_eq("s1_no_pulses",    32'(uf_seen + ds_seen), 32'd0);
        chk_eq("s1_locked",       32'(locked), 32'd0);

        // Continuous valid frames: lock at the first boundary.
        clear_stats();
        autofill = 1'b1;
        drive();
        repeat (4 * FT) step();
        chk_eq("s2_lock_pos",  32'(lock_pos), 32'd0);
        chk_eq("s2_underflow", 32'(uf_seen),  32'd0);
        chk_eq("s2_desync",    32'(ds_seen),  32'd0);
        chk_eq("s2_locked",    32'(locked),   32'd1);

        // Junk before SOF after a fresh reset.
        rst = 1'b1;
        q.delete();
        autofill = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) q.push_back('{d: DW'($urandom), u: 1'b0, l: 1'($urandom)});
        autofill = 1'b1;
        rand_data = 1'b1;
        clear_stats();
        drive();
        step();
        rst = 1'b0;
        repeat (3) step();
        chk_eq("s3_junk_flushed", 32'(q[0].u), 32'd1);
        repeat (3 * FT) step();
        chk_eq("s3_lock_pos", 32'(lock_pos), 32'd0);
        chk_eq("s3_errors",   32'(uf_seen + ds_seen), 32'd0);
        chk_eq("s3_locked",   32'(locked), 32'd1);

        // Single missing beat at pixel (3,1).
        clear_stats();
        drop_armed = 1'b1;
        repeat (4 * FT) step();
        chk_eq("s4_underflow_cnt", 32'(uf_seen), 32'd1);
        chk_eq("s4_underflow_pos", 32'(uf_pos),  32'(HT + 3 + 1));
        chk_eq("s4_desync",        32'(ds_seen), 32'd0);
        chk_eq("s4_relocked",      32'(locked),  32'd1);

        // One frame with 7-pixel lines.
        clear_stats();
        rand_data = 1'b0;
        bad_next  = 1'b1;
        repeat (4 * FT) step();
        chk_eq("s5_desync_cnt", 32'(ds_seen), 32'd1);
        chk_eq("s5_desync_pos", 32'(ds_pos),  32'd7);
        chk_eq("s5_underflow",  32'(uf_seen), 32'd0);
        chk_eq("s5_relocked",   32'(locked),  32'd1);

        // Reset mid-line 2 of a locked frame, stream left intact.
        begin
            int guard;
            guard = 0;
            while (!(m_locked && (k % FT) == 2 * HT + 3) && guard < 4 * FT) begin
                step();
                guard++;
            end
            chk_eq("s6_reached_line2", 32'(guard < 4 * FT), 32'd1);
        end
        rst = 1'b1;
        #1;
        chk_eq("s6_async_de",     32'(vid_de),     32'd0);
        chk_eq("s6_async_locked", 32'(locked),     32'd0);
        chk_eq("s6_async_tready", 32'(vbus.tready), 32'd0);
        repeat (3) step();
        rst = 1'b0;
        clear_stats();
        repeat (3 * FT) step();
        chk_eq("s6_relocked", 32'(locked), 32'd1);
        chk_eq("s6_errors",   32'(uf_seen + ds_seen), 32'd0);

        // Random gaps, random data and occasional malformed frames.
        rand_data = 1'b1;
        gap_pct   = 2;
        for (int f = 0; f < 10; f++) begin
            if ($urandom_range(3) == 0) bad_next = 1'b1;
            repeat (FT) step();
        end
        gap_pct = 0;
        repeat (3 * FT) step();
        chk_eq("s7_recovered", 32'(locked), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
